// File: rtl/player_key_conditioner.sv
// Per-key input conditioning: polarity fix, two-flop sync, debounce, rising-edge one-shot.
// Optional press counters are built when PLAYER_KEY_CONDITIONER_PRESS_COUNT_EN is defined.
module player_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l_raw,
  input  logic       key_r_raw,
  input  logic       en,
  output logic       L,
  output logic       R
`ifdef PLAYER_KEY_CONDITIONER_PRESS_COUNT_EN
  ,
  output logic [7:0] press_cnt_l,
  output logic [7:0] press_cnt_r
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is the left key, 1 is the right key.
  logic [1:0]    pressed_s;
  logic [1:0]    s1_r;
  logic [1:0]    s2_r;
  logic [1:0]    stable_r;
  logic [1:0]    stable_nxt_s;
  logic [1:0]    rise_s;
  logic [CW-1:0] cnt_r     [2];
  logic [CW-1:0] cnt_nxt_s [2];
  logic          l_r;
  logic          r_r;

  assign pressed_s = {key_r_raw, key_l_raw} ^ {2{ACTIVE_LOW}};

  // Debounce next-state and gated rising-edge detect for both channels.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_nxt_s[i] = stable_r[i];
      cnt_nxt_s[i]    = cnt_r[i];
      if (s2_r[i] == stable_r[i]) begin
        cnt_nxt_s[i] = {CW{1'b0}};
      end else if (cnt_r[i] == CNT_LAST) begin
        stable_nxt_s[i] = s2_r[i];
        cnt_nxt_s[i]    = {CW{1'b0}};
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
      end
      rise_s[i] = en & stable_nxt_s[i] & ~stable_r[i];
    end
  end

  // Synchronizer, debounce state and registered move pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r     <= 2'b00;
      s2_r     <= 2'b00;
      stable_r <= 2'b00;
      cnt_r[0] <= {CW{1'b0}};
      cnt_r[1] <= {CW{1'b0}};
      l_r      <= 1'b0;
      r_r      <= 1'b0;
    end else begin
      s1_r     <= pressed_s;
      s2_r     <= s1_r;
      stable_r <= stable_nxt_s;
      cnt_r[0] <= cnt_nxt_s[0];
      cnt_r[1] <= cnt_nxt_s[1];
      l_r      <= rise_s[0];
      r_r      <= rise_s[1];
    end
  end

  assign L = l_r;
  assign R = r_r;

`ifdef PLAYER_KEY_CONDITIONER_PRESS_COUNT_EN
  logic [7:0] pcnt_r [2];

  // Saturating press counters, advanced on the same edge the pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_r[0] <= 8'd0;
      pcnt_r[1] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (rise_s[i] && (pcnt_r[i] != 8'd255)) begin
          pcnt_r[i] <= pcnt_r[i] + 8'd1;
        end else begin
          pcnt_r[i] <= pcnt_r[i];
        end
      end
    end
  end

  assign press_cnt_l = pcnt_r[0];
  assign press_cnt_r = pcnt_r[1];
`endif

endmodule
